// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared definitions for the fetch stage.
//   fetch_state_t  : IDLE / RUN / HALT (2-bit encoding)
//   kTARG0..kTARG3 : branch LUT entries, absolute 8-bit targets by default;
//                    signed 8-bit PC offsets when FETCH_REL_BRANCH_EN is defined.
// Optional feature macro: FETCH_REL_BRANCH_EN
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_t;

`ifdef FETCH_REL_BRANCH_EN
   localparam logic [7:0] kTARG0 = 8'hFC;   // -4
   localparam logic [7:0] kTARG1 = 8'h08;   // +8
   localparam logic [7:0] kTARG2 = 8'hF0;   // -16
   localparam logic [7:0] kTARG3 = 8'h03;   // +3
`else
   localparam logic [7:0] kTARG0 = 8'd16;
   localparam logic [7:0] kTARG1 = 8'd40;
   localparam logic [7:0] kTARG2 = 8'd100;
   localparam logic [7:0] kTARG3 = 8'd3;
`endif

endpackage

// File: rtl/fetch_unit_branch_lut.sv
// branch_lut: combinational 4-entry map from the decoder's TargSel to an
// 8-bit branch LUT entry (absolute target or signed offset, see package).
//   TargSel : input  [1:0] target selector
//   Entry   : output [7:0] selected LUT entry
module branch_lut
   import fetch_unit_pkg::*;
(
   input  logic [1:0] TargSel,
   output logic [7:0] Entry
);

   always_comb begin
      Entry = kTARG0;
      case (TargSel)
         2'd0: Entry = kTARG0;
         2'd1: Entry = kTARG1;
         2'd2: Entry = kTARG2;
         2'd3: Entry = kTARG3;
         default: Entry = kTARG0;
      endcase
   end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: program-counter / instruction-fetch stage with run/halt
// handshake and a saturating retired-instruction counter.
//   Clk, Reset_n   : clock, asynchronous active-low reset
//   Start          : launch request, honoured in IDLE or HALT
//   Stall          : freezes PC, state and counter for the cycle
//   Halt           : decoder Ack, current instruction is the last one
//   Jump, BranchEn : taken-branch qualifiers from the decoder
//   TargSel        : branch LUT selector
//   ProgCtr        : registered instruction-ROM address
//   Running, Done  : registered RUN / HALT state flags
//   InstCount      : registered saturating retired-instruction count
// Optional feature macro: FETCH_REL_BRANCH_EN (PC-relative branch targets).
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int unsigned PC_W       = 10,
   parameter int unsigned START_ADDR = 0,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Start,
   input  logic             Stall,
   input  logic             Halt,
   input  logic             Jump,
   input  logic             BranchEn,
   input  logic [1:0]       TargSel,
   output logic [PC_W-1:0]  ProgCtr,
   output logic             Running,
   output logic             Done,
   output logic [CNT_W-1:0] InstCount
);

   fetch_state_t     state, state_next;
   logic [PC_W-1:0]  pc_next;
   logic [CNT_W-1:0] cnt_next;
   logic [CNT_W-1:0] cnt_inc;
   logic [PC_W-1:0]  target;
   logic [7:0]       lut_entry;

   branch_lut u_lut (
      .TargSel (TargSel),
      .Entry   (lut_entry)
   );

`ifdef FETCH_REL_BRANCH_EN
   logic signed [7:0] offset;
   assign offset = lut_entry;
   // Sign-extending cast of the offset; the sum wraps modulo 2**PC_W.
   assign target = ProgCtr + PC_W'(offset);
`else
   assign target = PC_W'(lut_entry);
`endif

   assign cnt_inc = (InstCount == '1) ? InstCount : InstCount + 1'b1;

   always_comb begin
      state_next = state;
      pc_next    = ProgCtr;
      cnt_next   = InstCount;
      case (state)
         IDLE, HALT: begin
            if (Start) begin
               state_next = RUN;
               pc_next    = PC_W'(START_ADDR);
               cnt_next   = '0;
            end
         end
         RUN: begin
            if (!Stall) begin
               cnt_next = cnt_inc;
               // Halt outranks a taken branch: the PC stays on the done instruction.
               if (Halt)
                  state_next = HALT;
               else if (BranchEn && Jump)
                  pc_next = target;
               else
                  pc_next = ProgCtr + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state     <= IDLE;
         ProgCtr   <= '0;
         InstCount <= '0;
         Running   <= 1'b0;
         Done      <= 1'b0;
      end else begin
         state     <= state_next;
         ProgCtr   <= pc_next;
         InstCount <= cnt_next;
         Running   <= (state_next == RUN);
         Done      <= (state_next == HALT);
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   localparam int PC_W  = 10;
   localparam int CNT_W = 4;
   localparam int START = 0;
   localparam int PCMOD = 1 << PC_W;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             Clk;
   logic             Reset_n;
   logic             Start, Stall, Halt, Jump, BranchEn;
   logic [1:0]       TargSel;
   logic [PC_W-1:0]  ProgCtr;
   logic             Running, Done;
   logic [CNT_W-1:0] InstCount;

   int checks = 0;
   int failures = 0;

   // Reference model: 0 = idle, 1 = running, 2 = halted
   int m_st, m_pc, m_cnt;

   fetch_unit #(.PC_W(PC_W), .START_ADDR(START), .CNT_W(CNT_W)) dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .Start     (Start),
      .Stall     (Stall),
      .Halt      (Halt),
      .Jump      (Jump),
      .BranchEn  (BranchEn),
      .TargSel   (TargSel),
      .ProgCtr   (ProgCtr),
      .Running   (Running),
      .Done      (Done),
      .InstCount (InstCount)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   function automatic int model_target(int pc, int sel);
`ifdef FETCH_REL_BRANCH_EN
      int rel[4] = '{-4, 8, -16, 3};
      return ((pc + rel[sel]) % PCMOD + PCMOD) % PCMOD;
`else
      int abs_t[4] = '{16, 40, 100, 3};
      return abs_t[sel];
`endif
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".pc"},      int'(ProgCtr),   m_pc);
      chk({tag, ".running"}, int'(Running),   (m_st == 1) ? 1 : 0);
      chk({tag, ".done"},    int'(Done),      (m_st == 2) ? 1 : 0);
      chk({tag, ".count"},   int'(InstCount), m_cnt);
   endtask

   task automatic model_reset();
      m_st = 0; m_pc = 0; m_cnt = 0;
   endtask

   // Called at a negedge; drives inputs, advances model, checks after posedge.
   task automatic step(input bit st, input bit sl, input bit hl, input bit jp,
                       input bit be, input bit [1:0] ts, input string tag);
      Start = st; Stall = sl; Halt = hl; Jump = jp; BranchEn = be; TargSel = ts;
      case (m_st)
         0, 2: if (st) begin m_st = 1; m_pc = START; m_cnt = 0; end
         default: if (!sl) begin
            m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
            if (hl)            m_st = 2;
            else if (be && jp) m_pc = model_target(m_pc, int'(ts));
            else               m_pc = (m_pc + 1) % PCMOD;
         end
      endcase
      @(posedge Clk);
      #1;
      check_all(tag);
      @(negedge Clk);
   endtask

   task automatic plain(input string tag);
      step(0, 0, 0, 0, 0, 2'd0, tag);
   endtask

   task automatic advance_to(input int pc, input int bound, input string tag);
      for (int i = 0; i < bound && m_pc != pc; i++) plain(tag);
      chk({tag, ".reached"}, int'(ProgCtr), pc);
   endtask

   initial begin
      Reset_n = 1'b0;
      Start = 0; Stall = 0; Halt = 0; Jump = 0; BranchEn = 0; TargSel = 2'd0;
      model_reset();
      #1;
      check_all("reset");
      @(negedge Clk);
      @(negedge Clk);
      Reset_n = 1'b1;

      // Idle ignores decoder inputs
      step(0, 0, 1, 1, 1, 2'd2, "idle_ignore");

      // Start then five plain cycles
      step(1, 0, 0, 0, 0, 2'd0, "start");
      chk("start.pc0", int'(ProgCtr), 0);
      for (int unsigned i = 0; i < 5; i++) plain("plain");
      chk("plain.pc5", int'(ProgCtr), 5);
      chk("plain.cnt5", int'(InstCount), 5);
      chk("plain.running", int'(Running), 1);

      // Taken branch at PC=7
      advance_to(7, 10, "to7");
      step(0, 0, 0, 1, 1, 2'd2, "branch");
`ifdef FETCH_REL_BRANCH_EN
      chk("branch.target", int'(ProgCtr), 1015);
`else
      chk("branch.target", int'(ProgCtr), 100);
`endif
      // Not-taken branch increments
      step(0, 0, 0, 0, 1, 2'd1, "not_taken");

      // Wrap from the top address
      advance_to(PCMOD - 1, 2 * PCMOD, "to_max");
      plain("wrap");
      chk("wrap.pc", int'(ProgCtr), 0);

      // Stall held three cycles at PC=20
      advance_to(20, 2 * PCMOD, "to20");
      for (int unsigned i = 0; i < 3; i++) step(0, 1, 1, 1, 1, 2'd1, "stall");
      chk("stall.pc", int'(ProgCtr), 20);

      // Halt together with a taken branch at PC=30
      advance_to(30, 2 * PCMOD, "to30");
      step(0, 0, 1, 1, 1, 2'd1, "halt");
      chk("halt.pc", int'(ProgCtr), 30);
      chk("halt.done", int'(Done), 1);
      chk("halt.running", int'(Running), 0);
      for (int unsigned i = 0; i < 3; i++) step(0, 0, 1, 1, 1, 2'(i), "halt_hold");
      step(1, 0, 0, 0, 0, 2'd0, "restart");
      chk("restart.pc", int'(ProgCtr), 0);
      chk("restart.done", int'(Done), 0);
      chk("restart.cnt", int'(InstCount), 0);

      // Asynchronous reset mid-run at PC=57
      advance_to(57, 2 * PCMOD, "to57");
      #2;
      Reset_n = 1'b0;
      model_reset();
      #1;
      check_all("async_reset");
      @(negedge Clk);
      Reset_n = 1'b1;
      step(1, 0, 0, 0, 0, 2'd0, "start_in_run_ignored_pre");
      step(1, 0, 0, 0, 0, 2'd0, "start_in_run_ignored");

      // Saturation: twenty instructions with a 4-bit counter
      step(0, 0, 1, 0, 0, 2'd0, "sat_halt");
      step(1, 0, 0, 0, 0, 2'd0, "sat_start");
      for (int unsigned i = 0; i < 20; i++) plain("sat");
      chk("sat.count", int'(InstCount), 15);

      // Randomized traffic against the model
      for (int unsigned i = 0; i < 400; i++) begin
         step(($urandom % 12) == 0, ($urandom % 4) == 0, ($urandom % 16) == 0,
              1'($urandom), 1'($urandom), 2'($urandom), "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch / program-counter stage feeding the instruction ROM, whose 9-bit output the control decoder consumes.
- Takes back the decoder's Jump, BranchEn, TargSel and Ack (as Halt) to select the next program counter each cycle.
- Owns the run/halt handshake with the testbench: Start launches a program, Done reports completion.
- Counts retired instructions for performance reporting.

Parameters:
- PC_W, 10, program-counter width; instruction ROM depth is 2**PC_W.
- START_ADDR, 0, PC value loaded on every Start.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- Clk  input  1  the single clock for the block.
- Reset_n  input  1  asynchronous active-low reset.
- Start  input  1  level-sampled launch request; honoured only in IDLE or HALT.
- Stall  input  1  hold request; freezes PC, state and counter for that cycle.
- Halt  input  1  decoder Ack; current instruction is the done instruction.
- Jump  input  1  decoder Jump (branch condition true).
- BranchEn  input  1  decoder BranchEn (instruction is a branch).
- TargSel  input  2  decoder branch-target selector.
- ProgCtr  output  PC_W  registered instruction-ROM address.
- Running  output  1  registered; high in RUN state.
- Done  output  1  registered; high in HALT state.
- InstCount  output  CNT_W  registered retired-instruction count, saturating.

Behaviour:
- Reset (Reset_n=0, asynchronous):
  - State=IDLE, ProgCtr=0, Running=0, Done=0, InstCount=0.
  - Reset overrides every other input, including an in-flight program.
- States: IDLE, RUN, HALT (2-bit encoding, defined in the package).
- IDLE:
  - All outputs hold their values; Jump, BranchEn, TargSel, Halt and Stall are ignored.
  - Start=1 → next cycle: RUN, ProgCtr=START_ADDR, InstCount=0.
- RUN, per-cycle priority Stall > Halt > branch > increment:
  - Stall=1: nothing changes.
  - Halt=1: → HALT; ProgCtr holds at the done instruction; InstCount+1.
  - BranchEn=1 && Jump=1: ProgCtr=target(TargSel); InstCount+1.
  - Otherwise: ProgCtr=ProgCtr+1 modulo 2**PC_W (max wraps to 0); InstCount+1.
  - BranchEn=1 with Jump=0 is a not-taken branch and increments normally.
  - Start is ignored in RUN.
- HALT:
  - Done=1; PC and InstCount frozen; all decoder inputs and Stall ignored.
  - Start=1 → RUN with ProgCtr=START_ADDR, InstCount=0, Done=0 on the same edge.
- InstCount saturates at 2**CNT_W-1 and never wraps.
- Latency: every ProgCtr change is visible one Clk edge after the deciding inputs.
- Running and Done are never both high; both are low in IDLE.
- Simultaneous Halt and taken branch in the same cycle: Halt wins; PC does not move.
- Absolute branch target: target = branch_lut[TargSel], zero-extended to PC_W.

Optional Feature:
- Macro: FETCH_REL_BRANCH_EN.
- Defined: the LUT entry is a signed 8-bit offset; target = ProgCtr + sign-extended offset, modulo 2**PC_W (wraps in both directions).
- Undefined: absolute targets as above; no adder is instantiated.

Decomposition:
- Shared package (the existing Definitions package) holds:
  - the fetch_state_t enum {IDLE, RUN, HALT};
  - kTARG0..kTARG3 (absolute: 16, 40, 100, 3; relative build: -4, +8, -16, +3).
- One sub-module, branch_lut: combinational 4-entry map TargSel → 8-bit entry, read from the package constants.

Test Plan:
- Reset_n pulsed low mid-RUN at PC=57 → ProgCtr=0, Running=0, Done=0, InstCount=0 immediately, with no clock edge required.
- Start, then 5 plain cycles → ProgCtr 0,1,2,3,4,5; InstCount=5; Running=1.
- In RUN at PC=7: BranchEn=1, Jump=1, TargSel=2 → next ProgCtr=100 (absolute build); same stimulus in the relative build → 7-16 wraps to 1015.
- At PC=1023 with no branch → next ProgCtr=0. Stall held 3 cycles at PC=20 → ProgCtr stays 20 and InstCount is unchanged.
- Halt=1 with BranchEn=1, Jump=1 at PC=30 → HALT, Done=1, ProgCtr=30.
  - Further Jump pulses → no change.
  - Start → ProgCtr=0, Done=0, InstCount=0.
- InstCount preloaded near saturation (CNT_W=4 build), 20 instructions run → count sticks at 15.
